mano_io_ctrl: RTL



---
 rtl/mano_io_ctrl_pkg.sv | 18 +
 rtl/mano_io_fifo.sv | 58 +++++
 rtl/mano_io_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mano_io_ctrl_pkg.sv
// mano_io_ctrl_pkg: shared constants for the multi-channel Mano I/O block.
// Optional feature macro: MANO_IO_IRQ_MASK_EN (interrupt mask register).
package mano_io_ctrl_pkg;

    localparam int IOW_DEF = 8;

    localparam int NCH_DEF   = 4;
    localparam int DEPTH_DEF = 4;

    localparam logic IRQ_DIR_IN  = 1'b0;
    localparam logic IRQ_DIR_OUT = 1'b1;

    // Channel index width, never narrower than one bit
    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mano_io_fifo.sv
// mano_io_fifo: first-word-fall-through synchronous FIFO, head reads 0 when empty.
// Full refuses push and empty refuses pop based on start-of-cycle occupancy.
module mano_io_fifo
    import mano_io_ctrl_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_din,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [W-1:0]               o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_head  = o_empty ? '0 : r_mem[r_rp];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointer and occupancy update; reset discards contents
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage write, suppressed while in reset
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push) r_mem[r_wp] <= i_din;
    end

endmodule

// File: rtl/mano_io_ctrl.sv
// mano_io_ctrl: NCH FIFO-buffered byte channels with a selected-channel CPU view.
// MANO_IO_IRQ_MASK_EN adds a loadable 2*NCH interrupt mask register.
module mano_io_ctrl
    import mano_io_ctrl_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int IOW   = IOW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CHW   = chw(NCH)
) (
    input  logic               mclk,
    input  logic               mrst,
    input  logic               cs_chsel_ld,
    input  logic [CHW-1:0]     chsel_in,
    output logic [CHW-1:0]     chsel,
    input  logic               cs_inp_rd,
    output logic [IOW-1:0]     inpr,
    output logic               fgi,
    input  logic               cs_out_wr,
    input  logic [IOW-1:0]     outr_in,
    output logic               fgo,
    input  logic               ien,
    output logic               irq,
    output logic [CHW-1:0]     irq_ch,
    output logic               irq_dir,
`ifdef MANO_IO_IRQ_MASK_EN
    input  logic               cs_mask_ld,
    input  logic [2*NCH-1:0]   mask_in,
`endif
    input  logic [NCH*IOW-1:0] dev_in_data,
    input  logic [NCH-1:0]     dev_in_valid,
    output logic [NCH-1:0]     dev_in_ready,
    output logic [NCH*IOW-1:0] dev_out_data,
    output logic [NCH-1:0]     dev_out_valid,
    input  logic [NCH-1:0]     dev_out_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [CHW-1:0]           r_chsel;
    logic                     r_irq;
    logic [CHW-1:0]           r_irq_ch;
    logic                     r_irq_dir;
    logic [2*NCH-1:0]         w_mask;
    logic [NCH-1:0]           w_in_empty;
    logic [NCH-1:0]           w_in_full;
    logic [NCH-1:0]           w_out_empty;
    logic [NCH-1:0]           w_out_full;
    logic [NCH-1:0]           w_in_pop;
    logic [NCH-1:0]           w_out_push;
    logic [NCH-1:0][IOW-1:0]  w_in_head;
    logic [NCH-1:0][IOW-1:0]  w_out_head;
    logic [NCH-1:0][AW:0]     w_in_cnt;
    logic [NCH-1:0][AW:0]     w_out_cnt;
    logic [NCH-1:0]           w_src_in;
    logic [NCH-1:0]           w_src_out;
    logic                     w_src_any;
    logic [CHW-1:0]           w_src_ch;
    logic                     w_src_dir;
    logic                     w_unused_cnt;

    // Occupancy counts are not needed at this level
    assign w_unused_cnt = ^{w_in_cnt, w_out_cnt};

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign w_in_pop[k]   = cs_inp_rd && (r_chsel == CHW'(k));
        assign w_out_push[k] = cs_out_wr && (r_chsel == CHW'(k));

        mano_io_fifo #(.W(IOW), .DEPTH(DEPTH)) u_in (
            .i_clk   (mclk),
            .i_rst_n (mrst),
            .i_push  (dev_in_valid[k]),
            .i_pop   (w_in_pop[k]),
            .i_din   (dev_in_data[k*IOW +: IOW]),
            .o_full  (w_in_full[k]),
            .o_empty (w_in_empty[k]),
            .o_count (w_in_cnt[k]),
            .o_head  (w_in_head[k])
        );

        mano_io_fifo #(.W(IOW), .DEPTH(DEPTH)) u_out (
            .i_clk   (mclk),
            .i_rst_n (mrst),
            .i_push  (w_out_push[k]),
            .i_pop   (dev_out_ready[k]),
            .i_din   (outr_in),
            .o_full  (w_out_full[k]),
            .o_empty (w_out_empty[k]),
            .o_count (w_out_cnt[k]),
            .o_head  (w_out_head[k])
        );

        assign dev_out_data[k*IOW +: IOW] = w_out_head[k];
    end

    assign dev_in_ready  = ~w_in_full;
    assign dev_out_valid = ~w_out_empty;

    assign chsel = r_chsel;
    assign inpr  = w_in_head[r_chsel];
    assign fgi   = ~w_in_empty[r_chsel];
    assign fgo   = ~w_out_full[r_chsel];

`ifdef MANO_IO_IRQ_MASK_EN
    logic [2*NCH-1:0] r_mask;

    // Interrupt mask register, every source enabled out of reset
    always_ff @(posedge mclk) begin
        if (!mrst)           r_mask <= '1;
        else if (cs_mask_ld) r_mask <= mask_in;
    end

    assign w_mask = r_mask;
`else
    assign w_mask = '1;
`endif

    assign w_src_in  = ~w_in_empty & w_mask[NCH-1:0];
    assign w_src_out = ~w_out_full & w_mask[2*NCH-1:NCH];

    // Fixed priority: lowest channel wins, input before output on a tie
    always_comb begin
        w_src_any = |(w_src_in | w_src_out);
        w_src_ch  = '0;
        w_src_dir = IRQ_DIR_IN;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (w_src_out[k]) begin
                w_src_ch  = CHW'(k);
                w_src_dir = IRQ_DIR_OUT;
            end
            if (w_src_in[k]) begin
                w_src_ch  = CHW'(k);
                w_src_dir = IRQ_DIR_IN;
            end
        end
    end

    // Channel select; out-of-range indices are ignored
    always_ff @(posedge mclk) begin
        if (!mrst)
            r_chsel <= '0;
        else if (cs_chsel_ld && (int'(chsel_in) < NCH))
            r_chsel <= chsel_in;
    end

    // Registered interrupt; source id holds while nothing is pending
    always_ff @(posedge mclk) begin
        if (!mrst) begin
            r_irq     <= 1'b0;
            r_irq_ch  <= '0;
            r_irq_dir <= IRQ_DIR_IN;
        end else begin
            r_irq <= ien && w_src_any;
            if (w_src_any) begin
                r_irq_ch  <= w_src_ch;
                r_irq_dir <= w_src_dir;
            end
        end
    end

    assign irq     = r_irq;
    assign irq_ch  = r_irq_ch;
    assign irq_dir = r_irq_dir;

endmodule
